pacc_sync_ctrl: RTL
===================

PACC_SYNC_CTRL -- requirements
Module: pacc_sync_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 23: signed width of accumulator sums.
REQ-002 The block SHALL have parameter WIN, default 64: number of valid samples to fill the accumulator window.
REQ-003 The block SHALL have parameter PLAT, default 16: consecutive above-threshold samples required for detection; legal range is 1 or more.
REQ-004 The block SHALL have parameter HOLD, default 320: valid samples ignored after a detection.
REQ-005 The block SHALL have parameter CW, default 16: width of the sample counters.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle request to begin a search.
REQ-009 The block SHALL have port abort, input, 1 bit: cancel any operation.
REQ-010 The block SHALL have port in_valid, input, 1 bit: one sample presented to the accumulator this cycle.
REQ-011 The block SHALL have ports sum_Re and sum_Im, input, WIDTH bits each, signed: current accumulator outputs.
REQ-012 The block SHALL have port thr, input, WIDTH+1 bits, unsigned: detection threshold, sampled every cycle.
REQ-013 The block SHALL have port acc_rst, output, 1 bit: active-high clear for the accumulator.
REQ-014 The block SHALL have port acc_ena, output, 1 bit: enable for the accumulator.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The block SHALL have port det, output, 1 bit: one-cycle detection pulse.
REQ-017 The block SHALL have port det_idx, output, CW bits: sample index of the detection.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse when HOLD completes.
REQ-019 The block SHALL have port state, output, 3 bits: current state for debug.

Function
REQ-020 The state machine SHALL have states IDLE=0, FILL=1, SEARCH=2, PLAT=3 and HOLD=4 and SHALL be held in a register.
REQ-021 acc_rst SHALL be 1 exactly when state is IDLE, decoded from the state register.
REQ-022 acc_ena SHALL equal in_valid whenever state is not IDLE, and SHALL be 0 in IDLE.
REQ-023 Magnitude mag SHALL be |sum_Re| + |sum_Im|, computed in WIDTH+1 bits without overflow: |-2^(WIDTH-1)| = 2^(WIDTH-1).
REQ-024 A sample SHALL qualify when in_valid=1 and mag > thr (strict); mag equal to thr does not qualify.
REQ-025 IDLE: start=1 SHALL move to FILL and clear idx, fill counter, run counter and hold counter.
REQ-026 FILL: each valid sample SHALL increment the fill counter; the WIN-th valid sample SHALL move to SEARCH; qualification is not evaluated in FILL.
REQ-027 SEARCH: a qualifying sample SHALL set run=1 and move to PLAT; if PLAT=1 it SHALL instead detect immediately per REQ-030.
REQ-028 PLAT: a qualifying sample SHALL increment run; a valid, non-qualifying sample SHALL clear run and return to SEARCH.
REQ-029 In any state, in_valid=0 SHALL leave state and counters unchanged, except for abort.
REQ-030 When run reaches PLAT, the block SHALL move to HOLD; det SHALL be 1 in the following cycle only; det_idx SHALL be updated in the same cycle det rises.
REQ-031 idx SHALL count valid samples from entering FILL, starting at 0 for the first sample, and SHALL saturate at 2^CW-1.
REQ-032 det_idx SHALL equal the idx of the sample that completed the plateau, and SHALL hold that value until the next detection.
REQ-033 HOLD: the block SHALL count HOLD valid samples and then move to IDLE; done SHALL be 1 in the following cycle only.
REQ-034 abort=1 SHALL move the block to IDLE on the next edge from any state, clear run, fill and hold counters, and suppress any det or done for that edge; abort SHALL take priority over start.
REQ-035 start outside IDLE SHALL be ignored.
REQ-036 After a detection, a new search SHALL begin only with a new start from IDLE.

Reset
REQ-037 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, all counters to 0, det=0, done=0 and det_idx=0.
REQ-038 During and after reset, outputs SHALL therefore be acc_rst=1, acc_ena=0 and busy=0.
REQ-039 Reset SHALL override start and abort, including a reset applied mid-operation.

Verification
Scenarios use WIN=4, PLAT=3, HOLD=5 and WIDTH=23.
REQ-040 Reset then start, 4 valid samples with sum=0: state goes FILL to SEARCH after the 4th; acc_ena tracks in_valid; acc_rst=0 from the FILL cycle.
REQ-041 In SEARCH with thr=100, samples at idx 4..6 with sum_Re=-60, sum_Im=50 (mag 110): det pulses once; det_idx=6; state goes to HOLD.
REQ-042 mag sequence 101, 101, 100 (equal to thr), then 101, 101, 101: no det after the first two; run clears; det_idx marks the 3rd sample of the second run.
REQ-043 Inputs sum_Re = sum_Im = -2^22 with thr = 2^23-1: mag=2^23 qualifies; no wrap to a negative or small value.
REQ-044 In PLAT with run=2, in_valid=0 for 3 cycles followed by 1 qualifying sample: det fires; the gaps do not break the run.
REQ-045 abort together with start, and abort on the qualifying 3rd sample: IDLE next cycle, no det, acc_rst=1; rst_n=0 in HOLD returns to IDLE with done=0.

Source files
------------

// File: rtl/pacc_sync_ctrl.sv
// pacc_sync_ctrl: search controller for a sliding-window correlation
// accumulator. It clears and enables the accumulator, waits for the window
// to fill, then looks for a plateau of PLAT consecutive valid samples whose
// |Re|+|Im| magnitude exceeds a threshold. On detection it reports the
// sample index and ignores HOLD further valid samples before going idle.
module pacc_sync_ctrl #(
    parameter int WIDTH = 23,
    parameter int WIN   = 64,
    parameter int PLAT  = 16,
    parameter int HOLD  = 320,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] sum_Re,
    input  logic signed [WIDTH-1:0] sum_Im,
    input  logic        [WIDTH:0]   thr,
    output logic                    acc_rst,
    output logic                    acc_ena,
    output logic                    busy,
    output logic                    det,
    output logic        [CW-1:0]    det_idx,
    output logic                    done,
    output logic        [2:0]       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_PLAT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    // Terminal values of the counters: the counter is compared before the
    // increment, so the last sample is the one seen at value N-1.
    localparam logic [CW-1:0] WIN_M1  = CW'(WIN - 1);
    localparam logic [CW-1:0] PLAT_M1 = CW'(PLAT - 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Absolute value widened by one bit so the most negative input maps to
    // +2^(WIDTH-1) instead of wrapping.
    function automatic logic [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] x);
        logic [WIDTH:0] xe;
        xe = {x[WIDTH-1], x};
        if (x[WIDTH-1]) begin
            abs_ext = ~xe + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_ext = xe;
        end
    endfunction

    // Saturating increment for the sample index.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_fill;
    logic [CW-1:0] r_run;
    logic [CW-1:0] r_hold;
    logic          r_det;
    logic          r_done;
    logic [CW-1:0] r_det_idx;
    logic [WIDTH:0] w_mag;
    logic          w_qual;
    logic          w_det_set;
    logic          w_done_set;
    logic          w_fill_last;
    logic          w_run_last;
    logic          w_hold_last;

    // Magnitude is at most 2^WIDTH, which fits the WIDTH+1 bit sum.
    assign w_mag       = abs_ext(sum_Re) + abs_ext(sum_Im);
    assign w_qual      = in_valid && (w_mag > thr);
    assign w_fill_last = (r_fill == WIN_M1);
    assign w_run_last  = (r_run == PLAT_M1);
    assign w_hold_last = (r_hold == HOLD_M1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the one-shot detect/done events.
    always_comb begin
        w_next_state = r_state;
        w_det_set    = 1'b0;
        w_done_set   = 1'b0;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = S_FILL;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_FILL: begin
                    if (in_valid && w_fill_last) begin
                        w_next_state = S_SEARCH;
                    end else begin
                        w_next_state = S_FILL;
                    end
                end
                S_SEARCH: begin
                    // run is 0 here, so w_run_last is true only for PLAT=1.
                    if (w_qual && w_run_last) begin
                        w_next_state = S_HOLD;
                        w_det_set    = 1'b1;
                    end else if (w_qual) begin
                        w_next_state = S_PLAT;
                    end else begin
                        w_next_state = S_SEARCH;
                    end
                end
                S_PLAT: begin
                    if (w_qual && w_run_last) begin
                        w_next_state = S_HOLD;
                        w_det_set    = 1'b1;
                    end else if (w_qual) begin
                        w_next_state = S_PLAT;
                    end else if (in_valid) begin
                        w_next_state = S_SEARCH;
                    end else begin
                        w_next_state = S_PLAT;
                    end
                end
                S_HOLD: begin
                    if (in_valid && w_hold_last) begin
                        w_next_state = S_IDLE;
                        w_done_set   = 1'b1;
                    end else begin
                        w_next_state = S_HOLD;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Sample index, fill, run and hold counters; only valid samples advance them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= CNT_ZERO;
            r_fill <= CNT_ZERO;
            r_run  <= CNT_ZERO;
            r_hold <= CNT_ZERO;
        end else if (abort) begin
            r_fill <= CNT_ZERO;
            r_run  <= CNT_ZERO;
            r_hold <= CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx  <= CNT_ZERO;
                        r_fill <= CNT_ZERO;
                        r_run  <= CNT_ZERO;
                        r_hold <= CNT_ZERO;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        r_idx  <= sat_inc(r_idx);
                        r_fill <= r_fill + CNT_ONE;
                    end
                end
                S_SEARCH, S_PLAT: begin
                    if (in_valid) begin
                        r_idx <= sat_inc(r_idx);
                        if (w_qual) begin
                            r_run <= r_run + CNT_ONE;
                        end else begin
                            r_run <= CNT_ZERO;
                        end
                    end
                end
                S_HOLD: begin
                    if (in_valid) begin
                        r_idx  <= sat_inc(r_idx);
                        r_hold <= r_hold + CNT_ONE;
                    end
                end
                default: begin
                    r_run <= CNT_ZERO;
                end
            endcase
        end
    end

    // Registered detect/done pulses and the captured detection index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_det     <= 1'b0;
            r_done    <= 1'b0;
            r_det_idx <= CNT_ZERO;
        end else begin
            r_det  <= w_det_set;
            r_done <= w_done_set;
            if (w_det_set) begin
                r_det_idx <= r_idx;
            end
        end
    end

    // Output decode from the state register.
    always_comb begin
        acc_rst = (r_state == S_IDLE);
        busy    = (r_state != S_IDLE);
        if (r_state != S_IDLE) begin
            acc_ena = in_valid;
        end else begin
            acc_ena = 1'b0;
        end
    end

    assign state   = r_state;
    assign det     = r_det;
    assign done    = r_done;
    assign det_idx = r_det_idx;

endmodule
